mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Round-robin controller that shares one instance of the team's combinational 4x4 `multiplier` (4-bit `a`, 4-bit `b`, 8-bit `product`) among up to eight requesters. It arbitrates operand requests, latches the winning operands, registers the product, and returns it with the requester's ID over a valid/ready handshake. It sits between client blocks and the shared multiplier, and is the only driver of the multiplier's inputs.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `ID_W`, 2, width of the returned requester ID; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has operands pending.
- `req_a`  in  4*NUM_REQ  operand A; requester i occupies [4i+3:4i].
- `req_b`  in  4*NUM_REQ  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted on an edge where `req_valid[i] && req_ready[i]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_product`  out  8  unsigned product of the granted operands.
- `out_id`  out  ID_W  index of the requester that owns `out_product`.
- `busy`  out  1  high in MUL or DONE.
- `op_count`  out  16  completed operations (present only with `MULT_SHARE_CNT_EN`).

## Operation
- State machine with three states:
  - IDLE: no operation in flight.
  - MUL: operands latched; multiplier inputs are driven from the operand registers.
  - DONE: result registered and `out_valid` = 1.
- Arbitration:
  - Search `req_valid` starting at pointer `ptr` and ascending modulo NUM_REQ; the first set bit wins.
  - `req_ready` is combinational. It is one-hot on the winner only when state = IDLE, or when state = DONE and `out_ready` = 1. It is all-zero otherwise and while `rst_n` is low.
- Transitions:
  - IDLE -> MUL on accept: latch operands and winner ID; set `ptr` = winner+1 mod NUM_REQ.
  - MUL -> DONE unconditionally: register `product` into `out_product`, ID into `out_id`, and set `out_valid` = 1.
  - DONE with `out_ready` = 1 and a new accept in the same cycle -> MUL (back-to-back operation).
  - DONE with `out_ready` = 1 and no request pending -> IDLE; `out_valid` falls.
  - DONE with `out_ready` = 0 -> stay in DONE.
- Arithmetic:
  - Unsigned 4x4 -> 8 bits; never overflows (15*15 = 225).
  - `out_product` and `out_id` are held stable for the whole time `out_valid` = 1.
- Inputs on non-granted requesters are ignored. Requesters must hold `req_valid` and operands until accepted.
- `ptr` advances only on an accept, never on idle cycles. It wraps from NUM_REQ-1 to 0.
- ID bits at and above NUM_REQ are zero.

## Timing
- Reset values (asynchronous, applied immediately when `rst_n` falls):
  - state = IDLE, `ptr` = 0.
  - `out_valid` = 0, `out_product` = 0, `out_id` = 0.
  - `busy` = 0, `op_count` = 0, `req_ready` = 0.
- Reset mid-operation discards the in-flight operation; no result is produced for it.
- Latency:
  - Accept at edge N -> `out_valid` = 1 after edge N+1.
  - Sustained throughput is one operation per 2 cycles when `out_ready` is held high.
- Backpressure: while DONE with `out_ready` = 0, `req_ready` = 0 and all outputs are frozen.
- `busy` is registered and reflects state (MUL or DONE).

## Configuration
- `MULT_SHARE_CNT_EN` defined:
  - `op_count` port exists.
  - It increments by 1 on each edge where `out_valid && out_ready`.
  - It saturates at 16'hFFFF.
  - It resets to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `req_valid` = 4'b0001 with A = 3, B = 5, `out_ready` = 1 -> `req_ready[0]` = 1 for one cycle; two edges later `out_valid` = 1, `out_product` = 15, `out_id` = 0.
- All four requesters valid from reset, with operands i+1 * i+1, `out_ready` = 1 -> grant order 0, 1, 2, 3, then 0 again; products 1, 4, 9, 16; one result every 2 cycles.
- A = 15, B = 15 on requester 2 -> `out_product` = 225, `out_id` = 2.
- Result pending with `out_ready` = 0 for 5 cycles while other requesters are valid -> `out_product` and `out_id` unchanged, `req_ready` = 0 throughout; `out_ready` = 1 grants the next requester in the same cycle.
- Assert `rst_n` = 0 during MUL -> `out_valid`, `busy` and `req_ready` go to 0 immediately; after release no stale result appears and `ptr` restarts at 0.
- With `MULT_SHARE_CNT_EN` defined: 6 completed handshakes -> `op_count` = 6; a cycle with `out_valid` = 1 and `out_ready` = 0 does not increment it.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one 4x4 unsigned multiplier among NUM_REQ requesters.
// Optional completed-operation counter (op_count port) enabled by defining MULT_SHARE_CNT_EN.
module mult_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_product,
  output logic [ID_W-1:0]        out_id,
`ifdef MULT_SHARE_CNT_EN
  output logic [15:0]            op_count,
`endif
  output logic                   busy
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [ID_W-1:0]   op_id;
  logic [PROD_W-1:0] mul_product;

  logic              hi_found;
  logic              lo_found;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   next_ptr;
  logic [OP_W-1:0]   win_a;
  logic [OP_W-1:0]   win_b;
  logic              grant_en;
  logic              accept;

  // Shared multiplier, fed only from the operand registers.
  assign mul_product = PROD_W'(op_a) * PROD_W'(op_b);

  // Round-robin pick: lowest valid index at/above ptr, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_idx) begin
        win_a = req_a[i*OP_W +: OP_W];
        win_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign grant_en  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = grant_en && lo_found;
  assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign next_ptr  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_id      <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MUL;
            op_a  <= win_a;
            op_b  <= win_b;
            op_id <= win_idx;
            ptr   <= next_ptr;
            busy  <= 1'b1;
          end
        end
        MUL: begin
          state       <= DONE;
          out_product <= mul_product;
          out_id      <= op_id;
          out_valid   <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state <= MUL;
              op_a  <= win_a;
              op_b  <= win_b;
              op_id <= win_idx;
              ptr   <= next_ptr;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_SHARE_CNT_EN
  // Saturating count of result handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level model checked every cycle plus directed literal checks.
// Counter checks are compiled in when MULT_SHARE_CNT_EN is defined.
module tb_mult_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_product;
  logic [1:0]  out_id;
  logic        busy;
`ifdef MULT_SHARE_CNT_EN
  logic [15:0] op_count;
`endif

  always #5 clk = ~clk;

  mult_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .out_id(out_id),
`ifdef MULT_SHARE_CNT_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = multiplying, 2 = result held.
  int          m_st;
  int          m_ptr;
  logic [3:0]  m_a;
  logic [3:0]  m_b;
  int          m_id;
  logic        m_valid;
  logic [7:0]  m_prod;
  logic [1:0]  m_oid;
  int          m_cnt;

  // DUT observations taken mid-cycle, logged at the following edge.
  logic [3:0]  s_acc;
  logic        s_out;
  logic [7:0]  s_prod;
  logic [1:0]  s_id;
  logic [3:0]  last_acc = '0;
  int          g_log[$];
  int          p_log[$];
  int          i_log[$];
  time         t_log[$];
  logic        auto_drop;

  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (p + k) % NUM_REQ;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    if (!rst_n) return 4'b0;
    if (!((m_st == 0) || ((m_st == 2) && out_ready))) return 4'b0;
    w = winner(req_valid, m_ptr);
    if (w < 0) return 4'b0;
    return 4'(1 << w);
  endfunction

  initial begin : model
    int   w;
    logic acc;
    m_st = 0; m_ptr = 0; m_a = '0; m_b = '0; m_id = 0;
    m_valid = 1'b0; m_prod = '0; m_oid = '0; m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_ptr = 0; m_valid = 1'b0; m_prod = '0; m_oid = '0; m_cnt = 0;
      end else begin
        if (|s_acc) begin
          for (int i = 0; i < NUM_REQ; i++) if (s_acc[2'(i)]) g_log.push_back(i);
        end
        if (s_out) begin
          p_log.push_back(int'(s_prod));
          i_log.push_back(int'(s_id));
          t_log.push_back($time);
        end
        w   = winner(req_valid, m_ptr);
        acc = (w >= 0) && ((m_st == 0) || ((m_st == 2) && out_ready));
        if (m_valid && out_ready && (m_cnt < 65535)) m_cnt++;
        if (m_st == 1) begin
          m_st    = 2;
          m_valid = 1'b1;
          m_prod  = 8'(m_a) * 8'(m_b);
          m_oid   = 2'(m_id);
        end else begin
          if (m_st == 2 && out_ready) begin
            m_valid = 1'b0;
            m_st    = 0;
          end
          if (acc) begin
            m_st  = 1;
            m_a   = 4'(req_a >> (4 * w));
            m_b   = 4'(req_b >> (4 * w));
            m_id  = w;
            m_ptr = (w + 1) % NUM_REQ;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      chk("cyc_req_ready", 32'(req_ready), 32'(exp_ready()));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_busy", 32'(busy), 32'(m_st != 0));
      chk("cyc_out_product", 32'(out_product), 32'(m_prod));
      chk("cyc_out_id", 32'(out_id), 32'(m_oid));
`ifdef MULT_SHARE_CNT_EN
      chk("cyc_op_count", 32'(op_count), 32'(m_cnt));
`endif
      s_acc    = req_valid & req_ready;
      s_out    = out_valid && out_ready;
      s_prod   = out_product;
      s_id     = out_id;
      last_acc = s_acc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (auto_drop) req_valid = req_valid & ~last_acc;
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic clear_logs();
    g_log.delete(); p_log.delete(); i_log.delete(); t_log.delete();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1; auto_drop = 1'b1;
    s_acc = '0; s_out = 1'b0; s_prod = '0; s_id = '0;

    // Reset holds everything low even with a pending request.
    set_op(0, 4'd3, 4'd5);
    req_valid = 4'b0001;
    step(2);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_product", 32'(out_product), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);

    // Single request: 3*5 from requester 0.
    step(1);
    rst_n = 1'b1;
    #1 chk("t1_grant", 32'(req_ready), 32'd1);
    step(1);
    #1 chk("t1_mul_valid", 32'(out_valid), 32'd0);
    chk("t1_mul_busy", 32'(busy), 32'd1);
    step(1);
    #1 chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_product", 32'(out_product), 32'd15);
    chk("t1_id", 32'(out_id), 32'd0);
    step(2);

    // All four requesting from reset: round-robin, one result per 2 cycles.
    rst_n = 1'b0;
    auto_drop = 1'b0;
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 4'(i + 1), 4'(i + 1));
    req_valid = 4'hF;
    step(2);
    rst_n = 1'b1;
    step(10);
    req_valid = '0;
    step(4);
    chk("t2_ngrant", 32'(g_log.size()), 32'd5);
    chk("t2_g0", 32'(g_log[0]), 32'd0);
    chk("t2_g1", 32'(g_log[1]), 32'd1);
    chk("t2_g2", 32'(g_log[2]), 32'd2);
    chk("t2_g3", 32'(g_log[3]), 32'd3);
    chk("t2_g4", 32'(g_log[4]), 32'd0);
    chk("t2_p0", 32'(p_log[0]), 32'd1);
    chk("t2_p1", 32'(p_log[1]), 32'd4);
    chk("t2_p2", 32'(p_log[2]), 32'd9);
    chk("t2_p3", 32'(p_log[3]), 32'd16);
    chk("t2_period", 32'(t_log[1] - t_log[0]), 32'd20);

    // Maximum operands on requester 2.
    auto_drop = 1'b1;
    clear_logs();
    set_op(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    step(5);
    chk("t3_nres", 32'(p_log.size()), 32'd1);
    chk("t3_product", 32'(p_log[0]), 32'd225);
    chk("t3_id", 32'(i_log[0]), 32'd2);

    // Backpressure: result held 5 cycles, then next requester granted same cycle.
    clear_logs();
    out_ready = 1'b0;
    set_op(0, 4'd2, 4'd7);
    set_op(1, 4'd3, 4'd4);
    req_valid = 4'b0011;
    step(2);
    #1 chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_product", 32'(out_product), 32'd14);
    chk("t4_id", 32'(out_id), 32'd0);
    step(5);
    out_ready = 1'b1;
    #1 chk("t4_hold_product", 32'(out_product), 32'd14);
    chk("t4_hold_id", 32'(out_id), 32'd0);
    chk("t4_next_grant", 32'(req_ready), 32'd2);
    step(4);
    chk("t4_nres", 32'(p_log.size()), 32'd2);
    chk("t4_p1", 32'(p_log[1]), 32'd12);
    chk("t4_i1", 32'(i_log[1]), 32'd1);

    // Reset during MUL discards the operation and restarts the pointer.
    set_op(3, 4'd9, 4'd9);
    req_valid = 4'b1000;
    step(1);
    #3 rst_n = 1'b0;
    #1 chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    step(2);
    rst_n = 1'b1;
    clear_logs();
    step(4);
    chk("t5_no_stale", 32'(p_log.size()), 32'd0);
    req_valid = 4'hF;
    #1 chk("t5_ptr_restart", 32'(req_ready), 32'd1);
    step(8);
    req_valid = '0;
    step(3);

`ifdef MULT_SHARE_CNT_EN
    // Six handshakes, then a stalled result that must not count.
    rst_n = 1'b0;
    auto_drop = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    #1 chk("cnt_reset", 32'(op_count), 32'd0);
    step(13);
    out_ready = 1'b0;
    req_valid = '0;
    step(3);
    #1 chk("cnt_six", 32'(op_count), 32'd6);
    chk("cnt_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step(3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
